// File: rtl/ex_scoreboard_pkg.sv
// ex_scoreboard_pkg: shared widths and helpers for the register-write scoreboard.
//   SB_RF_ADDR_WIDTH : default register address width (2**W tracked registers)
//   SB_CNT_WIDTH     : default per-register in-flight counter width
//   hit2()           : counts two one-bit hits into a 0..2 value
package ex_scoreboard_pkg;

    localparam int unsigned SB_RF_ADDR_WIDTH = 5;
    localparam int unsigned SB_CNT_WIDTH     = 2;

    // Number of lanes (0..2) that hit the same register in one cycle.
    function automatic logic [1:0] hit2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/ex_scoreboard_if.sv
// ex_scoreboard_if: pipeline <-> scoreboard bundle.
//   master : issue/writeback side; drives flush, alloc*, wb*, q* and reads results
//   slave  : scoreboard; reads requests, drives busy/ldbusy, issue_stall, sb_err
interface ex_scoreboard_if #(
    parameter int unsigned RF_ADDR_WIDTH = ex_scoreboard_pkg::SB_RF_ADDR_WIDTH
);

    logic                     flush;

    logic                     alloc0_valid;
    logic [RF_ADDR_WIDTH-1:0] alloc0_rd;
    logic                     alloc0_ld;
    logic                     alloc1_valid;
    logic [RF_ADDR_WIDTH-1:0] alloc1_rd;
    logic                     alloc1_ld;

    logic                     wb0_valid;
    logic [RF_ADDR_WIDTH-1:0] wb0_rd;
    logic                     wb0_ld;
    logic                     wb1_valid;
    logic [RF_ADDR_WIDTH-1:0] wb1_rd;
    logic                     wb1_ld;

    logic [RF_ADDR_WIDTH-1:0] q0_rs1;
    logic [RF_ADDR_WIDTH-1:0] q0_rs2;
    logic [RF_ADDR_WIDTH-1:0] q1_rs1;
    logic [RF_ADDR_WIDTH-1:0] q1_rs2;

    logic                     q0_rs1_busy;
    logic                     q0_rs2_busy;
    logic                     q1_rs1_busy;
    logic                     q1_rs2_busy;
    logic                     q0_rs1_ldbusy;
    logic                     q0_rs2_ldbusy;
    logic                     q1_rs1_ldbusy;
    logic                     q1_rs2_ldbusy;

    logic                     issue_stall;
    logic                     sb_err;

    modport master (
        output flush,
        output alloc0_valid, alloc0_rd, alloc0_ld,
        output alloc1_valid, alloc1_rd, alloc1_ld,
        output wb0_valid, wb0_rd, wb0_ld,
        output wb1_valid, wb1_rd, wb1_ld,
        output q0_rs1, q0_rs2, q1_rs1, q1_rs2,
        input  q0_rs1_busy, q0_rs2_busy, q1_rs1_busy, q1_rs2_busy,
        input  q0_rs1_ldbusy, q0_rs2_ldbusy, q1_rs1_ldbusy, q1_rs2_ldbusy,
        input  issue_stall, sb_err
    );

    modport slave (
        input  flush,
        input  alloc0_valid, alloc0_rd, alloc0_ld,
        input  alloc1_valid, alloc1_rd, alloc1_ld,
        input  wb0_valid, wb0_rd, wb0_ld,
        input  wb1_valid, wb1_rd, wb1_ld,
        input  q0_rs1, q0_rs2, q1_rs1, q1_rs2,
        output q0_rs1_busy, q0_rs2_busy, q1_rs1_busy, q1_rs2_busy,
        output q0_rs1_ldbusy, q0_rs2_ldbusy, q1_rs1_ldbusy, q1_rs2_ldbusy,
        output issue_stall, sb_err
    );

endinterface

// File: rtl/ex_scoreboard_sb_cnt_cell.sv
// sb_cnt_cell: in-flight write/load counters for one architectural register.
//   clk, rst_n     : clock, async active-low reset
//   flush          : synchronous clear of both counters (wins over updates)
//   wr_inc/wr_dec  : accepted allocations / writebacks this cycle (0..2)
//   ld_inc/ld_dec  : load-only subset of the above (0..2)
//   wr_cnt/ld_cnt  : registered counter values
//   underflow_c    : combinational, a decrement would take a counter below zero
module sb_cnt_cell
    import ex_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = SB_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [1:0]           wr_inc,
    input  logic [1:0]           wr_dec,
    input  logic [1:0]           ld_inc,
    input  logic [1:0]           ld_dec,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    output logic [CNT_WIDTH-1:0] ld_cnt,
    output logic                 underflow_c
);

    localparam int unsigned SUM_W   = CNT_WIDTH + 2;
    localparam int unsigned CNT_MAX = (1 << CNT_WIDTH) - 1;

    logic [CNT_WIDTH-1:0] wr_next;
    logic [CNT_WIDTH-1:0] ld_next;
    logic                 wr_uf;
    logic                 ld_uf;

    // Net update cnt + inc - dec, clamped to [0, CNT_MAX]; MSB flags underflow.
    function automatic logic [CNT_WIDTH:0] sat_update(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [1:0]           inc,
        input logic [1:0]           dec
    );
        logic [SUM_W-1:0] up;
        logic [SUM_W-1:0] res;
        logic             uf;
        up  = SUM_W'(cnt) + SUM_W'(inc);
        uf  = (up < SUM_W'(dec));
        res = uf ? '0 : (up - SUM_W'(dec));
        if (res > SUM_W'(CNT_MAX)) begin
            res = SUM_W'(CNT_MAX);
        end
        return {uf, CNT_WIDTH'(res)};
    endfunction

    // Next-state for both counters.
    always_comb begin
        {wr_uf, wr_next} = sat_update(wr_cnt, wr_inc, wr_dec);
        {ld_uf, ld_next} = sat_update(ld_cnt, ld_inc, ld_dec);
        underflow_c      = wr_uf | ld_uf;
    end

    // Counter state; flush overrides any same-cycle alloc/writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            ld_cnt <= '0;
        end else if (flush) begin
            wr_cnt <= '0;
            ld_cnt <= '0;
        end else begin
            wr_cnt <= wr_next;
            ld_cnt <= ld_next;
        end
    end

endmodule

// File: rtl/ex_scoreboard.sv
// ex_scoreboard: dual-issue register-write scoreboard.
//   clk, rst_n : clock, async active-low reset
//   sb (slave) : alloc0/1 issue-time allocations, wb0/1 writebacks, flush,
//                q0/q1 operand queries -> busy (bypass) / ldbusy (stall),
//                issue_stall (combinational), sb_err (sticky underflow flag)
// busy/ldbusy/issue_stall are combinational on purpose: writebacks of the
// current cycle are written through so the issuing bundle sees them at once.
module ex_scoreboard
    import ex_scoreboard_pkg::*;
#(
    parameter int unsigned RF_ADDR_WIDTH = SB_RF_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH     = SB_CNT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_scoreboard_if.slave sb
);

    localparam int unsigned NUM_REGS = 1 << RF_ADDR_WIDTH;
    localparam int unsigned SUM_W    = CNT_WIDTH + 2;
    localparam int unsigned CNT_MAX  = (1 << CNT_WIDTH) - 1;

    typedef logic [RF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [CNT_WIDTH-1:0]     cnt_t;

    cnt_t                wr_cnt [NUM_REGS];
    cnt_t                ld_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] underflow;

    addr_t alloc_rd   [2];
    logic  alloc_ld   [2];
    logic  alloc_cand [2];
    logic  alloc_acc  [2];
    addr_t wb_rd      [2];
    logic  wb_ld      [2];
    logic  wb_hit     [2];
    logic  lane_sat   [2];

    addr_t q_rs     [4];
    logic  q_busy   [4];
    logic  q_ldbusy [4];

    logic issue_stall_c;
    logic sb_err_q;

    // Lane views of the bundle; x0 requests are dropped here.
    assign alloc_rd[0]   = sb.alloc0_rd;
    assign alloc_rd[1]   = sb.alloc1_rd;
    assign alloc_ld[0]   = sb.alloc0_ld;
    assign alloc_ld[1]   = sb.alloc1_ld;
    assign alloc_cand[0] = sb.alloc0_valid && (sb.alloc0_rd != '0);
    assign alloc_cand[1] = sb.alloc1_valid && (sb.alloc1_rd != '0);
    assign wb_rd[0]      = sb.wb0_rd;
    assign wb_rd[1]      = sb.wb1_rd;
    assign wb_ld[0]      = sb.wb0_ld;
    assign wb_ld[1]      = sb.wb1_ld;
    assign wb_hit[0]     = sb.wb0_valid && (sb.wb0_rd != '0);
    assign wb_hit[1]     = sb.wb1_valid && (sb.wb1_rd != '0);

    assign q_rs[0] = sb.q0_rs1;
    assign q_rs[1] = sb.q0_rs2;
    assign q_rs[2] = sb.q1_rs1;
    assign q_rs[3] = sb.q1_rs2;

    // Operand queries with write-through of this cycle's writebacks.
    // Lane-1 queries deliberately ignore a same-cycle lane-0 allocation.
    for (genvar q = 0; q < 4; q++) begin : g_query
        logic [1:0] wb_n;
        logic [1:0] ld_wb_n;
        assign wb_n    = hit2(wb_hit[0] && (wb_rd[0] == q_rs[q]),
                              wb_hit[1] && (wb_rd[1] == q_rs[q]));
        assign ld_wb_n = hit2(wb_hit[0] && wb_ld[0] && (wb_rd[0] == q_rs[q]),
                              wb_hit[1] && wb_ld[1] && (wb_rd[1] == q_rs[q]));
        assign q_busy[q]   = (q_rs[q] != '0) && (SUM_W'(wr_cnt[q_rs[q]]) > SUM_W'(wb_n));
        assign q_ldbusy[q] = (q_rs[q] != '0) && (SUM_W'(ld_cnt[q_rs[q]]) > SUM_W'(ld_wb_n));
    end

    // Per-lane overflow check: count + both lanes' allocs to rd - writebacks to rd.
    for (genvar l = 0; l < 2; l++) begin : g_lane
        localparam int unsigned OTHER = 1 - l;
        logic [1:0] cand_n;
        logic [1:0] wb_n;
        assign cand_n = hit2(alloc_cand[l],
                             alloc_cand[OTHER] && (alloc_rd[OTHER] == alloc_rd[l]));
        assign wb_n   = hit2(wb_hit[0] && (wb_rd[0] == alloc_rd[l]),
                             wb_hit[1] && (wb_rd[1] == alloc_rd[l]));
        assign lane_sat[l] = alloc_cand[l] &&
            ((SUM_W'(wr_cnt[alloc_rd[l]]) + SUM_W'(cand_n)) > (SUM_W'(CNT_MAX) + SUM_W'(wb_n)));
    end

    // Any load-pending source or any overflowing lane holds the whole bundle.
    assign issue_stall_c = q_ldbusy[0] | q_ldbusy[1] | q_ldbusy[2] | q_ldbusy[3] |
                           lane_sat[0] | lane_sat[1];

    assign alloc_acc[0] = alloc_cand[0] && !issue_stall_c;
    assign alloc_acc[1] = alloc_cand[1] && !issue_stall_c;

    // x0 is never tracked.
    assign wr_cnt[0]    = '0;
    assign ld_cnt[0]    = '0;
    assign underflow[0] = 1'b0;

    // One counter cell per architectural register.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        localparam addr_t REG_IDX = addr_t'(r);
        logic a0, a1, w0, w1;
        assign a0 = alloc_acc[0] && (alloc_rd[0] == REG_IDX);
        assign a1 = alloc_acc[1] && (alloc_rd[1] == REG_IDX);
        assign w0 = wb_hit[0] && (wb_rd[0] == REG_IDX);
        assign w1 = wb_hit[1] && (wb_rd[1] == REG_IDX);

        sb_cnt_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (sb.flush),
            .wr_inc      (hit2(a0, a1)),
            .wr_dec      (hit2(w0, w1)),
            .ld_inc      (hit2(a0 && alloc_ld[0], a1 && alloc_ld[1])),
            .ld_dec      (hit2(w0 && wb_ld[0], w1 && wb_ld[1])),
            .wr_cnt      (wr_cnt[r]),
            .ld_cnt      (ld_cnt[r]),
            .underflow_c (underflow[r])
        );
    end

    // Sticky underflow flag; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err_q <= 1'b0;
        end else if (|underflow) begin
            sb_err_q <= 1'b1;
        end
    end

    assign sb.q0_rs1_busy   = q_busy[0];
    assign sb.q0_rs2_busy   = q_busy[1];
    assign sb.q1_rs1_busy   = q_busy[2];
    assign sb.q1_rs2_busy   = q_busy[3];
    assign sb.q0_rs1_ldbusy = q_ldbusy[0];
    assign sb.q0_rs2_ldbusy = q_ldbusy[1];
    assign sb.q1_rs1_ldbusy = q_ldbusy[2];
    assign sb.q1_rs2_ldbusy = q_ldbusy[3];
    assign sb.issue_stall   = issue_stall_c;
    assign sb.sb_err        = sb_err_q;

endmodule

// File: tb/tb_ex_scoreboard.sv
// tb_ex_scoreboard: directed scenarios plus randomized traffic, checked against
// a count-per-register reference model held in plain integer arrays.
module tb_ex_scoreboard;

    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 2;
    localparam int          NREG = 32;
    localparam int          MAXC = 3;

    logic clk;
    logic rst_n;

    ex_scoreboard_if #(.RF_ADDR_WIDTH(AW)) sbif();

    ex_scoreboard #(
        .RF_ADDR_WIDTH (AW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding writes / loads per register, sticky error.
    int m_wr [NREG];
    int m_ld [NREG];
    bit m_err;
    bit m_accept;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        sbif.flush        = 1'b0;
        sbif.alloc0_valid = 1'b0; sbif.alloc0_rd = '0; sbif.alloc0_ld = 1'b0;
        sbif.alloc1_valid = 1'b0; sbif.alloc1_rd = '0; sbif.alloc1_ld = 1'b0;
        sbif.wb0_valid    = 1'b0; sbif.wb0_rd    = '0; sbif.wb0_ld    = 1'b0;
        sbif.wb1_valid    = 1'b0; sbif.wb1_rd    = '0; sbif.wb1_ld    = 1'b0;
        sbif.q0_rs1 = '0; sbif.q0_rs2 = '0; sbif.q1_rs1 = '0; sbif.q1_rs2 = '0;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_wr[r] = 0;
            m_ld[r] = 0;
        end
        m_err = 1'b0;
    endtask

    // Writebacks to register rs this cycle (loads only when ldo).
    function automatic int wb_count(input int rs, input bit ldo);
        int n = 0;
        if (rs == 0) return 0;
        if (sbif.wb0_valid && int'(sbif.wb0_rd) == rs && (!ldo || sbif.wb0_ld)) n++;
        if (sbif.wb1_valid && int'(sbif.wb1_rd) == rs && (!ldo || sbif.wb1_ld)) n++;
        return n;
    endfunction

    // Allocation requests to register r this cycle (loads only when ldo).
    function automatic int alloc_count(input int r, input bit ldo);
        int n = 0;
        if (r == 0) return 0;
        if (sbif.alloc0_valid && int'(sbif.alloc0_rd) == r && (!ldo || sbif.alloc0_ld)) n++;
        if (sbif.alloc1_valid && int'(sbif.alloc1_rd) == r && (!ldo || sbif.alloc1_ld)) n++;
        return n;
    endfunction

    function automatic bit exp_busy(input int rs, input bit ldo);
        int pend;
        if (rs == 0) return 1'b0;
        pend = (ldo ? m_ld[rs] : m_wr[rs]) - wb_count(rs, ldo);
        return pend > 0;
    endfunction

    // Compare all outputs with the model for the inputs currently applied.
    task automatic model_check();
        int    qs [4];
        logic  gb [4];
        logic  gl [4];
        string qn [4];
        bit    any_ld = 1'b0;
        bit    sat = 1'b0;
        int    rd;
        qn = '{"q0_rs1", "q0_rs2", "q1_rs1", "q1_rs2"};
        qs[0] = int'(sbif.q0_rs1); qs[1] = int'(sbif.q0_rs2);
        qs[2] = int'(sbif.q1_rs1); qs[3] = int'(sbif.q1_rs2);
        gb[0] = sbif.q0_rs1_busy;   gb[1] = sbif.q0_rs2_busy;
        gb[2] = sbif.q1_rs1_busy;   gb[3] = sbif.q1_rs2_busy;
        gl[0] = sbif.q0_rs1_ldbusy; gl[1] = sbif.q0_rs2_ldbusy;
        gl[2] = sbif.q1_rs1_ldbusy; gl[3] = sbif.q1_rs2_ldbusy;
        for (int i = 0; i < 4; i++) begin
            check_eq({qn[i], "_busy"},   32'(gb[i]), 32'(exp_busy(qs[i], 1'b0)));
            check_eq({qn[i], "_ldbusy"}, 32'(gl[i]), 32'(exp_busy(qs[i], 1'b1)));
            if (exp_busy(qs[i], 1'b1)) any_ld = 1'b1;
        end
        rd = int'(sbif.alloc0_rd);
        if (sbif.alloc0_valid && rd != 0 && m_wr[rd] + alloc_count(rd, 1'b0) - wb_count(rd, 1'b0) > MAXC)
            sat = 1'b1;
        rd = int'(sbif.alloc1_rd);
        if (sbif.alloc1_valid && rd != 0 && m_wr[rd] + alloc_count(rd, 1'b0) - wb_count(rd, 1'b0) > MAXC)
            sat = 1'b1;
        m_accept = !(any_ld || sat);
        check_eq("issue_stall", 32'(sbif.issue_stall), 32'(!m_accept));
        check_eq("sb_err", 32'(sbif.sb_err), 32'(m_err));
    endtask

    // Advance the model by one clock edge.
    task automatic model_update();
        int nw, nl;
        for (int r = 1; r < NREG; r++) begin
            nw = m_wr[r] + (m_accept ? alloc_count(r, 1'b0) : 0) - wb_count(r, 1'b0);
            nl = m_ld[r] + (m_accept ? alloc_count(r, 1'b1) : 0) - wb_count(r, 1'b1);
            if (nw < 0) begin m_err = 1'b1; nw = 0; end
            if (nl < 0) begin m_err = 1'b1; nl = 0; end
            if (nw > MAXC) nw = MAXC;
            if (nl > MAXC) nl = MAXC;
            if (sbif.flush) begin nw = 0; nl = 0; end
            m_wr[r] = nw;
            m_ld[r] = nl;
        end
    endtask

    // Entered and left at a falling edge, with inputs already applied.
    task automatic cycle();
        #1;
        model_check();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek();
        #1;
    endtask

    // Asynchronous reset in the middle of a low clock phase.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_q0_rs1_busy",   32'(sbif.q0_rs1_busy),   0);
        check_eq("rst_q0_rs2_busy",   32'(sbif.q0_rs2_busy),   0);
        check_eq("rst_q1_rs1_busy",   32'(sbif.q1_rs1_busy),   0);
        check_eq("rst_q1_rs2_busy",   32'(sbif.q1_rs2_busy),   0);
        check_eq("rst_q0_rs2_ldbusy", 32'(sbif.q0_rs2_ldbusy), 0);
        check_eq("rst_q1_rs2_ldbusy", 32'(sbif.q1_rs2_ldbusy), 0);
        check_eq("rst_issue_stall",   32'(sbif.issue_stall),   0);
        check_eq("rst_sb_err",        32'(sbif.sb_err),        0);
        model_clear();
        idle();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick();
        return ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 8);
    endfunction

    task automatic rand_inputs();
        int r;
        idle();
        if ($urandom % 3 != 0) begin
            sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = AW'(pick()); sbif.alloc0_ld = ($urandom % 5 == 0);
        end
        if ($urandom % 3 != 0) begin
            sbif.alloc1_valid = 1'b1; sbif.alloc1_rd = AW'(pick()); sbif.alloc1_ld = ($urandom % 5 == 0);
        end
        r = pick();
        if ((m_wr[r] > 0 || $urandom % 40 == 0) && $urandom % 3 != 0) begin
            sbif.wb0_valid = 1'b1; sbif.wb0_rd = AW'(r); sbif.wb0_ld = (m_ld[r] > 0) && ($urandom % 4 != 0);
        end
        r = pick();
        if ((m_wr[r] > 0 || $urandom % 40 == 0) && $urandom % 3 != 0) begin
            sbif.wb1_valid = 1'b1; sbif.wb1_rd = AW'(r); sbif.wb1_ld = (m_ld[r] > 0) && ($urandom % 4 != 0);
        end
        sbif.q0_rs1 = AW'(pick()); sbif.q0_rs2 = AW'(pick());
        sbif.q1_rs1 = AW'(pick()); sbif.q1_rs2 = AW'(pick());
        if ($urandom % 50 == 0) begin
            sbif.flush     = 1'b1;
            sbif.wb0_valid = 1'b0;
            sbif.wb1_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_clear();
        m_accept = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        sbif.q0_rs1 = 5'd5; sbif.q1_rs2 = 5'd7;
        peek();
        check_eq("init_busy",   32'(sbif.q0_rs1_busy), 0);
        check_eq("init_stall",  32'(sbif.issue_stall), 0);
        check_eq("init_sb_err", 32'(sbif.sb_err),      0);
        cycle(); idle();

        // ALU allocation, query next cycle, writeback clears in same cycle
        sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd5;
        cycle(); idle();
        sbif.q0_rs1 = 5'd5;
        peek();
        check_eq("alu_busy",   32'(sbif.q0_rs1_busy),   1);
        check_eq("alu_ldbusy", 32'(sbif.q0_rs1_ldbusy), 0);
        check_eq("alu_stall",  32'(sbif.issue_stall),   0);
        cycle();
        cycle();
        sbif.wb0_valid = 1'b1; sbif.wb0_rd = 5'd5;
        peek();
        check_eq("alu_wb_busy", 32'(sbif.q0_rs1_busy), 0);
        cycle(); idle();

        // Load allocation stalls a dependent lane-1 query until its writeback
        sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd7; sbif.alloc0_ld = 1'b1;
        cycle(); idle();
        sbif.q1_rs2 = 5'd7;
        peek();
        check_eq("ld_ldbusy", 32'(sbif.q1_rs2_ldbusy), 1);
        check_eq("ld_stall",  32'(sbif.issue_stall),   1);
        cycle();
        sbif.wb0_valid = 1'b1; sbif.wb0_rd = 5'd7; sbif.wb0_ld = 1'b1;
        peek();
        check_eq("ld_wb_ldbusy", 32'(sbif.q1_rs2_ldbusy), 0);
        check_eq("ld_wb_stall",  32'(sbif.issue_stall),   0);
        cycle(); idle();

        // Dual allocation to the same register counts twice
        sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd9;
        sbif.alloc1_valid = 1'b1; sbif.alloc1_rd = 5'd9;
        cycle(); idle();
        sbif.q0_rs1 = 5'd9; sbif.wb0_valid = 1'b1; sbif.wb0_rd = 5'd9;
        peek();
        check_eq("dual_wb0_busy", 32'(sbif.q0_rs1_busy), 1);
        cycle(); idle();
        sbif.q0_rs1 = 5'd9; sbif.wb1_valid = 1'b1; sbif.wb1_rd = 5'd9;
        peek();
        check_eq("dual_wb1_busy", 32'(sbif.q0_rs1_busy), 0);
        cycle(); idle();
        sbif.q0_rs1 = 5'd9;
        peek();
        check_eq("dual_empty_busy", 32'(sbif.q0_rs1_busy), 0);
        cycle(); idle();

        // Counter saturation stalls the whole bundle unless a writeback frees a slot
        repeat (3) begin
            sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd3;
            cycle();
        end
        idle();
        sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd3;
        sbif.alloc1_valid = 1'b1; sbif.alloc1_rd = 5'd4;
        sbif.q0_rs1 = 5'd3; sbif.q0_rs2 = 5'd4;
        peek();
        check_eq("sat_stall", 32'(sbif.issue_stall), 1);
        cycle();
        peek();
        check_eq("sat_dropped_busy", 32'(sbif.q0_rs2_busy), 0);
        sbif.wb0_valid = 1'b1; sbif.wb0_rd = 5'd3;
        peek();
        check_eq("sat_wb_stall", 32'(sbif.issue_stall), 0);
        cycle(); idle();
        sbif.q0_rs2 = 5'd4;
        peek();
        check_eq("sat_accepted_busy", 32'(sbif.q0_rs2_busy), 1);
        cycle(); idle();
        sbif.wb0_valid = 1'b1; sbif.wb0_rd = 5'd3;
        sbif.wb1_valid = 1'b1; sbif.wb1_rd = 5'd3;
        cycle(); idle();
        sbif.wb0_valid = 1'b1; sbif.wb0_rd = 5'd3;
        sbif.wb1_valid = 1'b1; sbif.wb1_rd = 5'd4;
        cycle(); idle();

        // x0 is untracked; writeback to an idle register sets sticky sb_err
        sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd0; sbif.q0_rs1 = 5'd0;
        peek();
        check_eq("x0_busy", 32'(sbif.q0_rs1_busy), 0);
        cycle(); idle();
        sbif.wb0_valid = 1'b1; sbif.wb0_rd = 5'd12;
        cycle(); idle();
        peek();
        check_eq("uf_sb_err", 32'(sbif.sb_err), 1);
        cycle(); idle();

        // Flush wins over a same-cycle allocation and leaves sb_err alone
        sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd10;
        sbif.alloc1_valid = 1'b1; sbif.alloc1_rd = 5'd11;
        cycle(); idle();
        sbif.flush = 1'b1; sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd8;
        cycle(); idle();
        sbif.q0_rs1 = 5'd8; sbif.q0_rs2 = 5'd10; sbif.q1_rs1 = 5'd11;
        peek();
        check_eq("flush_rd8_busy",  32'(sbif.q0_rs1_busy), 0);
        check_eq("flush_rd10_busy", 32'(sbif.q0_rs2_busy), 0);
        check_eq("flush_rd11_busy", 32'(sbif.q1_rs1_busy), 0);
        check_eq("flush_sb_err",    32'(sbif.sb_err),      1);
        cycle(); idle();

        // Asynchronous reset mid-operation
        sbif.alloc0_valid = 1'b1; sbif.alloc0_rd = 5'd13;
        sbif.alloc1_valid = 1'b1; sbif.alloc1_rd = 5'd14; sbif.alloc1_ld = 1'b1;
        cycle(); idle();
        sbif.q0_rs1 = 5'd13; sbif.q0_rs2 = 5'd14;
        peek();
        check_eq("pre_rst_busy",   32'(sbif.q0_rs1_busy),   1);
        check_eq("pre_rst_ldbusy", 32'(sbif.q0_rs2_ldbusy), 1);
        do_reset();

        // Randomized traffic with periodic resets
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            if (c % 600 == 599) begin
                do_reset();
            end else begin
                cycle();
            end
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_scoreboard.md
# ex_scoreboard

Register-write scoreboard for the dual-issue integer pipeline. It is the producer-side counterpart of the EX forwarding unit. Each issue lane allocates its destination register at issue, and the block tracks every in-flight write until writeback. It answers operand-readiness queries for the next bundle and separates ALU-pending registers (bypassable) from load-pending registers (must stall). It also rejects allocations that would overflow its per-register counters.

## Interface
Parameters:
- RF_ADDR_WIDTH, 5, register address width; 2**RF_ADDR_WIDTH tracked registers.
- CNT_WIDTH, 2, per-register in-flight counter width; max outstanding writes per register = 2**CNT_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all counters (branch mispredict/trap).
- alloc0_valid, alloc1_valid  in  1  lane 0/1 issues an instruction that writes rd.
- alloc0_rd, alloc1_rd  in  RF_ADDR_WIDTH  destination register.
- alloc0_ld, alloc1_ld  in  1  the allocating instruction is a load.
- wb0_valid, wb1_valid  in  1  lane 0/1 writes back to the register file this cycle.
- wb0_rd, wb1_rd  in  RF_ADDR_WIDTH  writeback destination.
- wb0_ld, wb1_ld  in  1  the writeback is a load result.
- q0_rs1, q0_rs2, q1_rs1, q1_rs2  in  RF_ADDR_WIDTH  source operands of the bundle being issued.
- q0_rs1_busy … q1_rs2_busy  out  1  source has an in-flight write (bypass required).
- q0_rs1_ldbusy … q1_rs2_ldbusy  out  1  source has an in-flight load write.
- issue_stall  out  1  any ldbusy query is true, or an allocation would saturate a counter.
- sb_err  out  1  sticky flag: a writeback was seen against a zero counter.

## Operation
- State: wr_cnt[r] and ld_cnt[r], each CNT_WIDTH bits. ld_cnt ≤ wr_cnt at all times.
- Register 0 is never tracked. Allocations and writebacks to x0 are ignored, and queries of x0 return 0.
- Allocation is accepted when allocN_valid && !issue_stall. An accepted allocation increments wr_cnt[rd], and also ld_cnt[rd] when allocN_ld is set.
- If both lanes allocate the same rd in one cycle, the counter increments by 2.
- A writeback with wbN_valid decrements wr_cnt[rd], and also ld_cnt[rd] when wbN_ld is set. Writebacks are never stalled.
- If both lanes write back the same rd in one cycle, the counter decrements by 2.
- Net update per register per cycle = accepted allocs − writebacks, computed in a single expression. Simultaneous alloc and wb to the same register leaves the count unchanged.
- Underflow: a decrement below 0 saturates at 0 and sets sb_err. sb_err clears only on reset.
- Saturation: if any accepted allocation would push wr_cnt past its max, issue_stall asserts and both lanes' allocations are dropped that cycle. The decision is all-or-nothing per bundle.
- Queries use write-through. busy = (wr_cnt[rs] − same-cycle writebacks to rs) != 0, and ldbusy is computed the same way from ld_cnt. A result written back this cycle is readable from the RF and is not reported.
- The scoreboard does not cover intra-bundle lane0→lane1 dependencies. That case is handled by the EX forwarding unit, so the q1 queries ignore same-cycle alloc0.
- flush clears all wr_cnt and ld_cnt to 0 on the next edge, overriding allocation and writeback in the same cycle. sb_err is unaffected by flush.

## Timing
- Reset: all counters 0; all busy/ldbusy outputs 0; issue_stall 0; sb_err 0.
- An allocation accepted at edge t is visible to queries from cycle t+1.
- A writeback presented in cycle t clears the register in the same cycle t (combinational write-through). It is reflected in state from t+1.
- issue_stall is combinational from current state, queries and alloc inputs. There is no registered latency.
- An asynchronous reset mid-operation zeros all state immediately. The first allocation is accepted in the cycle after rst_n deasserts.

## Structure
- Shared package/Define include: RF_ADDR_WIDTH and a SB_CNT_WIDTH default.
- Natural sub-module: sb_cnt_cell, one per register. It holds one wr_cnt/ld_cnt pair and performs the saturating ±2 update with underflow detect. Instantiate it with a generate loop for r = 1..2**RF_ADDR_WIDTH−1.
- The top level holds the query muxes, stall logic and sb_err.

## Test plan
- Alloc0 rd=5 (ALU) at t0; q0_rs1=5 at t1 → q0_rs1_busy=1, ldbusy=0, issue_stall=0. wb0 rd=5 at t3 → q busy=0 in t3.
- Alloc0 rd=7 load; next cycle q1_rs2=7 → q1_rs2_ldbusy=1, issue_stall=1. Load wb rd=7 → ldbusy=0 and stall drops in the same cycle.
- Both lanes alloc rd=9 in one cycle, then wb0 rd=9 → busy remains 1. wb1 rd=9 → busy 0, counter 0.
- Allocate rd=3 three times (CNT_WIDTH=2), then alloc0 rd=3 plus alloc1 rd=4 → issue_stall=1 and neither count changes. Same cycle wb rd=3 → the allocation is accepted.
- Alloc rd=0 and query rs=0 → no state change, busy=0. wb rd=12 with count 0 → sb_err=1 and stays set through a later flush.
- With several registers busy, assert flush alongside alloc rd=8 → all busy=0 next cycle and rd=8 is not tracked. Assert rst_n low mid-sequence → all outputs 0 immediately.
